// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
// Holds the board timing constants (the soc_defs values) used as top-level defaults and the
// debounce window derivation.
package input_conditioner_pkg;

  // Board timing constants.
  localparam int unsigned SOC_CLK_PERIOD_NS = 20;
  localparam int unsigned SOC_DEBOUNCE_NS   = 30_000_000;

  // Number of clock cycles an input must stay different from the stable level before it is
  // committed. Clamped to at least one so that a very short debounce time still works.
  function automatic int unsigned calc_cnt_max(input int unsigned debounce_ns,
                                               input int unsigned period_ns);
    int unsigned r;
    r = debounce_ns / period_ns;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side/core-side signal bundle of the input conditioner.
// master: the core side, drives enable and sig_i and observes the conditioned outputs.
// slave:  the conditioner itself.
//   enable   global debounce count enable
//   sig_i    raw asynchronous inputs
//   level_o  debounced stable level
//   rise_o   one-cycle pulse on 0->1 of level_o
//   fall_o   one-cycle pulse on 1->0 of level_o
//   toggle_o flips on each rise_o pulse
//   event_o  OR of all rise_o/fall_o bits
interface input_conditioner_if #(
  parameter int unsigned N_CH = 8
);
  logic            enable;
  logic [N_CH-1:0] sig_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] toggle_o;
  logic            event_o;

  modport master (
    output enable, sig_i,
    input  level_o, rise_o, fall_o, toggle_o, event_o
  );

  modport slave (
    input  enable, sig_i,
    output level_o, rise_o, fall_o, toggle_o, event_o
  );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: synchroniser chain, debounce counter, stable level, edge pulses and
// toggle latch.
//   clk       system clock, all state on rising edge
//   reset     synchronous active-high reset
//   enable    debounce count enable (synchroniser always runs)
//   sig_i     raw asynchronous input
//   level_o   debounced stable level
//   rise_o    one-cycle pulse after a 0->1 commit
//   fall_o    one-cycle pulse after a 1->0 commit
//   toggle_o  flips on each rise
//   commit_o  combinational: stable level updates at the coming edge (feeds the event register)
module debounce_channel #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_MAX     = 4,
  parameter int unsigned CNT_W       = 3,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o,
  output logic commit_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   toggle_q, toggle_d;
  logic                   commit;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    commit   = 1'b0;
    if (s == stable_q) begin
      // Input back at the stable level: discard the partial count, even while disabled.
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CntLast) begin
        stable_d = s;
        cnt_d    = '0;
        commit   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d   = commit & s;
    fall_d   = commit & ~s;
    toggle_d = toggle_q ^ rise_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{RST_VAL}};
      cnt_q    <= '0;
      stable_q <= RST_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level_o  = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign toggle_o = toggle_q;
  assign commit_o = commit;

endmodule

// File: rtl/input_conditioner.sv
// N-channel input front end: per-channel synchroniser and debounce with registered level,
// rise/fall pulses, toggle latch and a combined event flag.
//   clk    system clock, all state on rising edge
//   reset  synchronous active-high reset
//   bus    slave side of input_conditioner_if (enable, sig_i in; level/rise/fall/toggle/event out)
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned    N_CH          = 8,
  parameter int unsigned    SYNC_STAGES   = 2,
  parameter int unsigned    CLK_PERIOD_NS = SOC_CLK_PERIOD_NS,
  parameter int unsigned    DEBOUNCE_NS   = SOC_DEBOUNCE_NS,
  parameter logic [N_CH-1:0] RESET_LEVEL  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input_conditioner_if.slave   bus
);

  localparam int unsigned CNT_MAX = calc_cnt_max(DEBOUNCE_NS, CLK_PERIOD_NS);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] commit;
  logic            event_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_MAX     (CNT_MAX),
      .CNT_W       (CNT_W),
      .RST_VAL     (RESET_LEVEL[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (bus.enable),
      .sig_i    (bus.sig_i[i]),
      .level_o  (level[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .toggle_o (toggle[i]),
      .commit_o (commit[i])
    );
  end

  // Registered from the commit strobes so it lands in the same cycle as the pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= 1'b0;
    end else begin
      event_q <= |commit;
    end
  end

  assign bus.level_o  = level;
  assign bus.rise_o   = rise;
  assign bus.fall_o   = fall;
  assign bus.toggle_o = toggle;
  assign bus.event_o  = event_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam logic [3:0] RstLvl = 4'b0010;
  localparam int unsigned Lat   = 6;  // SYNC_STAGES + CNT_MAX

  typedef struct packed {
    int unsigned cycle;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  level;
    logic [3:0]  tog;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exp_t       sb_q[$];
  logic [3:0] exp_level, exp_tog;  // model state after all pushed commits
  logic [3:0] cur_level, cur_tog;  // what the outputs must show right now

  input_conditioner_if #(.N_CH(4)) bus ();

  input_conditioner #(
    .N_CH          (4),
    .SYNC_STAGES   (2),
    .CLK_PERIOD_NS (1),
    .DEBOUNCE_NS   (4),
    .RESET_LEVEL   (RstLvl)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].cycle == cyc) begin
      e = sb_q.pop_front();
      check_eq("rise", 32'(bus.rise_o), 32'(e.rise));
      check_eq("fall", 32'(bus.fall_o), 32'(e.fall));
      check_eq("event", 32'(bus.event_o), 32'd1);
      check_eq("level_commit", 32'(bus.level_o), 32'(e.level));
      check_eq("toggle_commit", 32'(bus.toggle_o), 32'(e.tog));
      cur_level = e.level;
      cur_tog   = e.tog;
    end else begin
      check_eq("rise_idle", 32'(bus.rise_o), 32'd0);
      check_eq("fall_idle", 32'(bus.fall_o), 32'd0);
      check_eq("event_idle", 32'(bus.event_o), 32'd0);
      check_eq("level", 32'(bus.level_o), 32'(cur_level));
      check_eq("toggle", 32'(bus.toggle_o), 32'(cur_tog));
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      monitor();
    end
  endtask

  // Drive a new input pattern and push the commit expected lat edges later.
  task automatic drive_step(input logic [3:0] v, input int unsigned lat);
    exp_t e;
    bus.sig_i = v;
    e.cycle = cyc + lat;
    e.rise  = v & ~exp_level;
    e.fall  = ~v & exp_level;
    e.level = v;
    e.tog   = exp_tog ^ e.rise;
    if ((e.rise | e.fall) != 4'b0000) sb_q.push_back(e);
    exp_level = v;
    exp_tog   = e.tog;
  endtask

  task automatic apply_reset(input int n, input logic [3:0] v);
    reset = 1'b1;
    bus.sig_i = v;
    sb_q.delete();
    exp_level = RstLvl;
    exp_tog   = '0;
    cur_level = RstLvl;
    cur_tog   = '0;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.sig_i  = 4'b1111;

    // Reset with all inputs high: level forced to the reset pattern, no pulses.
    apply_reset(3, 4'b1111);
    // ch0/ch2/ch3 differ from the reset level and debounce normally; ch1 already matches.
    drive_step(4'b1111, Lat);
    tick(8);
    drive_step(4'b0000, Lat);
    tick(8);

    // Clean toggle baseline.
    apply_reset(2, RstLvl);
    drive_step(4'b0011, Lat);
    tick(8);
    drive_step(4'b0010, Lat);
    tick(8);
    drive_step(4'b0011, Lat);
    tick(8);
    check_eq("toggle0_after_two_rises", 32'(bus.toggle_o[0]), 32'd0);

    // ch2 glitch: three synced high cycles reach cnt=CNT_MAX-1 but never commit.
    bus.sig_i = 4'b0111;
    tick(3);
    bus.sig_i = 4'b0011;
    tick(8);
    drive_step(4'b0111, Lat);
    tick(8);

    // ch3 step with enable low for 5 cycles mid-count.
    drive_step(4'b1111, Lat + 5);
    tick(3);
    bus.enable = 1'b0;
    tick(5);
    bus.enable = 1'b1;
    tick(6);

    // ch0 and ch3 fall together: single event cycle.
    drive_step(4'b0110, Lat);
    tick(8);

    // Reset in the middle of a ch0 count aborts it; full debounce after release.
    drive_step(4'b0111, Lat);
    tick(5);
    apply_reset(1, 4'b0111);
    check_eq("level_after_midcount_reset", 32'(bus.level_o), 32'(RstLvl));
    drive_step(4'b0111, Lat);
    tick(9);

    check_eq("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
